// File: rtl/dbus_translator_pkg.sv
// Shared data-bus types, translator FSM states and MIPS segment tags.
package dbus_translator_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} dbt_state_t;

  localparam logic [2:0] KSEG0_TAG = 3'b100;
  localparam logic [2:0] KSEG1_TAG = 3'b101;

endpackage

// File: rtl/dbus_translator_if.sv
// Core-side and memory-side bus bundle of the data-bus translator.
interface dbus_translator_if;
  dbus_translator_pkg::dbus_req_t  creq;
  dbus_translator_pkg::dbus_resp_t cresp;
  dbus_translator_pkg::dbus_req_t  mreq;
  dbus_translator_pkg::dbus_resp_t mresp;
  logic                            uncached;
  logic                            busy;

  modport slave  (input  creq, mresp, output cresp, mreq, uncached, busy);
  modport master (output creq, mresp, input  cresp, mreq, uncached, busy);
endinterface

// File: rtl/dbus_translator_seg_map.sv
// Combinational MIPS segment map: kseg0/kseg1 are masked to physical, kseg1 is uncached.
module seg_map
  import dbus_translator_pkg::*;
#(
  parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
  input  logic [31:0] vaddr_i,
  output logic [31:0] paddr_o,
  output logic        uncached_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    paddr_o    = vaddr_i;
    uncached_o = 1'b0;
    case (vaddr_i[31:29])
      KSEG0_TAG: paddr_o = vaddr_i & PHYS_MASK;
      KSEG1_TAG: begin
        paddr_o    = vaddr_i & PHYS_MASK;
        uncached_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dbus_translator.sv
// Registered data-bus stage: latches one core request, translates its address,
// holds it toward memory until accepted and returns a one-cycle completion.
module dbus_translator
  import dbus_translator_pkg::*;
#(
  parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
  input  logic               clk,
  input  logic               reset,
  dbus_translator_if.slave   bus
);

  dbt_state_t  state_q, state_d;
  dbus_req_t   req_q, req_d;
  logic        unc_q, unc_d;
  logic [31:0] data_q, data_d;
  logic [31:0] paddr;
  logic        seg_unc;

  seg_map #(.PHYS_MASK(PHYS_MASK)) u_seg_map (
    .vaddr_i    (bus.creq.addr),
    .paddr_o    (paddr),
    .uncached_o (seg_unc)
  );

  // NOTE: state uses non-blocking assignments; the request/data latches are
  // reset as well so mreq and cresp read as all-zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      unc_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      unc_q   <= unc_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unc_d   = unc_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.creq.valid) begin
          req_d       = bus.creq;
          req_d.valid = 1'b0;
          req_d.addr  = paddr;
          unc_d       = seg_unc;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        // data_ok without addr_ok is a protocol violation and is ignored here
        if (bus.mresp.addr_ok && bus.mresp.data_ok) begin
          data_d  = bus.mresp.data;
          state_d = DONE;
        end else if (bus.mresp.addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.mresp.data_ok) begin
          data_d  = bus.mresp.data;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mreq     = {state_q == ADDR, req_q.addr, req_q.size, req_q.strobe, req_q.data};
  assign bus.cresp    = (state_q == DONE) ? {1'b1, 1'b1, data_q} : '0;
  assign bus.uncached = unc_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dbus_translator.sv
// Directed bench for dbus_translator with a response scoreboard and monitor.
module tb_dbus_translator;
  import dbus_translator_pkg::*;

  typedef logic [71:0] cval_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dbus_translator_if bus();

  dbus_translator #(.PHYS_MASK(32'h1FFF_FFFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string name, input cval_t act, input cval_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the next queued read-back value.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.cresp.data_ok === 1'b1) begin
        logic [31:0] e;
        if (sb_q.size() == 0) begin
          check("unexpected_resp", cval_t'(bus.cresp.data_ok), cval_t'(0));
        end else begin
          e = sb_q.pop_front();
          check("resp_data", cval_t'(bus.cresp.data), cval_t'(e));
          check("resp_addr_ok", cval_t'(bus.cresp.addr_ok), cval_t'(1));
        end
      end
    end
  end

  // Core side: present a request (called at a falling edge).
  task automatic start(input logic [31:0] addr, input logic [3:0] strobe,
                       input logic [31:0] wdata, input bit push, input logic [31:0] rdata);
    bus.creq = '{1'b1, addr, 3'd2, strobe, wdata};
    if (push) sb_q.push_back(rdata);
  endtask

  // Memory side: stall addr_wait cycles in ADDR, then data_wait cycles to data_ok.
  task automatic serve(input logic [31:0] exp_addr, input logic exp_unc,
                       input int addr_wait, input int data_wait,
                       input logic [31:0] rdata, input bit stall_dok, input bit alter);
    dbus_req_t exp_req;
    exp_req       = bus.creq;
    exp_req.valid = 1'b1;
    exp_req.addr  = exp_addr;
    for (int i = 0; i <= addr_wait; i++) begin
      @(negedge clk);
      check("mreq_hold", cval_t'(bus.mreq), cval_t'(exp_req));
      check("uncached", cval_t'(bus.uncached), cval_t'(exp_unc));
      if (alter && i == 0) bus.creq.addr = 32'hA000_0200;
      if (i == addr_wait) bus.mresp = '{1'b1, data_wait == 0, rdata};
      else                bus.mresp = '{1'b0, stall_dok, 32'hFFFF_FFFF};
    end
    for (int j = 1; j <= data_wait; j++) begin
      @(negedge clk);
      check("mreq_off_in_data", cval_t'(bus.mreq.valid), cval_t'(0));
      check("busy_in_data", cval_t'(bus.busy), cval_t'(1));
      if (j == data_wait) bus.mresp = '{1'b0, 1'b1, rdata};
      else                bus.mresp = '0;
    end
    @(negedge clk);
    bus.mresp = '0;
    check("resp_pulse", cval_t'(bus.cresp.data_ok), cval_t'(1));
    bus.creq.valid = 1'b0;
    @(negedge clk);
    check("resp_single", cval_t'(bus.cresp.data_ok), cval_t'(0));
    check("idle_busy", cval_t'(bus.busy), cval_t'(0));
    check("idle_mreq", cval_t'(bus.mreq.valid), cval_t'(0));
  endtask

  initial begin
    bus.creq  = '0;
    bus.mresp = '0;
    reset     = 1'b1;
    // Reset held 3 cycles with a kseg0 read already waiting.
    start(32'h8000_1234, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mreq_valid", cval_t'(bus.mreq.valid), cval_t'(0));
      check("rst_cresp", cval_t'(bus.cresp), cval_t'(0));
      check("rst_busy", cval_t'(bus.busy), cval_t'(0));
    end
    reset = 1'b0;
    serve(32'h0000_1234, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // kseg1 write: addr_ok after 3 stall cycles, data_ok 2 cycles later.
    start(32'hBFC0_0010, 4'hF, 32'h1122_3344, 1'b1, 32'hCAFE_0001);
    serve(32'h1FC0_0010, 1'b1, 3, 2, 32'hCAFE_0001, 1'b0, 1'b0);

    // kuseg passthrough, one stall cycle.
    start(32'h0040_0000, 4'h0, 32'h0, 1'b1, 32'h0BAD_F00D);
    serve(32'h0040_0000, 1'b0, 1, 0, 32'h0BAD_F00D, 1'b0, 1'b0);

    // creq altered in ADDR, stray data_ok during stalls; then the new request.
    start(32'h8000_0100, 4'h0, 32'h0, 1'b1, 32'h1357_9BDF);
    serve(32'h0000_0100, 1'b0, 2, 1, 32'h1357_9BDF, 1'b1, 1'b1);
    start(32'hA000_0200, 4'h3, 32'h0000_ABCD, 1'b1, 32'h2468_ACE0);
    serve(32'h0000_0200, 1'b1, 0, 1, 32'h2468_ACE0, 1'b0, 1'b0);

    // Reset while in DATA: no completion may follow.
    start(32'h9000_0000, 4'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("mid_mreq_valid", cval_t'(bus.mreq.valid), cval_t'(1));
    check("mid_mreq_addr", cval_t'(bus.mreq.addr), cval_t'(32'h1000_0000));
    bus.mresp = '{1'b1, 1'b0, 32'h0};
    @(negedge clk);
    check("mid_busy_data", cval_t'(bus.busy), cval_t'(1));
    reset     = 1'b1;
    bus.mresp = '{1'b0, 1'b1, 32'h5555_5555};
    @(negedge clk);
    check("mid_rst_busy", cval_t'(bus.busy), cval_t'(0));
    check("mid_rst_mreq", cval_t'(bus.mreq.valid), cval_t'(0));
    check("mid_rst_resp", cval_t'(bus.cresp.data_ok), cval_t'(0));
    reset          = 1'b0;
    bus.mresp      = '0;
    bus.creq.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_resp", cval_t'(bus.cresp.data_ok), cval_t'(0));
    end

    check("sb_empty", cval_t'(sb_q.size()), cval_t'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_translator.md
# dbus_translator

Data-bus stage placed directly downstream of the core's memory stage, between the core's `dbus_req_t`/`dbus_resp_t` port and the memory/cache side. It registers each core request and maps unmapped MIPS segments (kseg0/kseg1) to physical addresses. It holds the request stable toward memory until accepted, then returns a single-cycle combined `addr_ok`/`data_ok` completion to the core. One request is outstanding at a time.

## Interface
Parameters:
- `PHYS_MASK`, default `32'h1FFF_FFFF`: mask applied to kseg0/kseg1 addresses.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `creq`  in  `dbus_req_t`: core request (`valid`, `addr`, `size`, `strobe`, `data`).
- `cresp`  out  `dbus_resp_t`: response to core (`addr_ok`, `data_ok`, `data`).
- `mreq`  out  `dbus_req_t`: request to memory side, physical address.
- `mresp`  in  `dbus_resp_t`: memory-side response.
- `uncached`  out  1: held request targets kseg1. Valid while `mreq.valid`.
- `busy`  out  1: FSM not in IDLE.

## Operation
- Address translation, on `creq.addr[31:29]`:
  - `3'b100` (kseg0) → `addr & PHYS_MASK`, `uncached=0`.
  - `3'b101` (kseg1) → `addr & PHYS_MASK`, `uncached=1`.
  - All other values → address unchanged, `uncached=0`.
- `size`, `strobe` and `data` are copied unchanged. `strobe==0` marks a read.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE: `mreq.valid=0`, `cresp` all zero. If `creq.valid` is high, latch the translated request and go to ADDR.
  - ADDR: `mreq` drives the latched request with `valid=1`.
    - `mresp.addr_ok && mresp.data_ok`: latch `mresp.data`, go to DONE.
    - `addr_ok` only: go to DATA.
    - Otherwise: stay in ADDR.
  - DATA: `mreq.valid=0`. On `mresp.data_ok`, latch `mresp.data` and go to DONE.
  - DONE: `cresp.addr_ok=1`, `cresp.data_ok=1`, `cresp.data` = latched data. Next state is IDLE.
- `creq` is ignored in ADDR, DATA and DONE. The core holds `creq` stable until it sees `cresp.data_ok`.
- For writes, `cresp.data` returns whatever memory drove with `data_ok`. The core ignores it.
- `mreq` fields are driven from the latch only. Nothing passes combinationally from `creq` to `mreq`.
- `cresp` is driven only from state and latches. Nothing passes combinationally from `mresp` to `cresp`.

## Timing
- Reset values: state IDLE; `mreq`, `cresp`, `uncached`, `busy`, latched request and latched data all 0.
- Latency: `creq.valid` sampled in cycle t → `mreq.valid` in t+1.
  - With 0-wait memory (`addr_ok` and `data_ok` in t+1), `cresp.data_ok` is asserted in t+2.
  - In general, `cresp.data_ok` is asserted exactly 1 cycle after `mresp.data_ok`.
- Back-to-back: the earliest next request is sampled in the cycle after DONE, so there is at least 1 idle cycle between transactions.
- `mreq` stays constant for every cycle the FSM is in ADDR.
- `mresp.data_ok` arriving in ADDR without `addr_ok` is a protocol violation and is ignored.
- `mresp` inputs in IDLE and DONE are ignored.
- Reset in any state returns the FSM to IDLE on the next edge. Memory is reset by the same `reset`, so no in-flight transaction survives.

## Structure
- Shared package / `common.svh`: `dbus_req_t`, `dbus_resp_t` (already present); a `dbt_state_t` enum {IDLE, ADDR, DATA, DONE}; segment constants `KSEG0_TAG=3'b100`, `KSEG1_TAG=3'b101`.
- One sub-module: `seg_map`, combinational. Inputs: virtual address. Outputs: physical address and `uncached`. It is reused later on the instruction bus.
- Top level holds the FSM, the request latch and the data latch. Estimated 150–250 lines.

## Test plan
- Reset and idle: hold `reset` 3 cycles with `creq.valid=1` → `mreq.valid=0`, `cresp=0`, `busy=0` throughout. After release, `mreq.valid=1` one cycle later.
- kseg0 read, 0-wait: `creq={valid=1, addr=32'h8000_1234, strobe=0}`; memory returns `addr_ok=data_ok=1`, `data=32'hDEAD_BEEF` →
  - `mreq.addr=32'h0000_1234`, `uncached=0`.
  - `cresp.data_ok=1` with `data=32'hDEAD_BEEF` exactly 2 cycles after `creq` is sampled.
- kseg1 write with backpressure: `addr=32'hBFC0_0010`, `strobe=4'hF`, `data=32'h1122_3344`; memory delays `addr_ok` 3 cycles and `data_ok` 2 further cycles →
  - `mreq` is held unchanged with `valid=1` for 4 cycles.
  - `mreq.addr=32'h1FC0_0010`, `uncached=1`.
  - `cresp.data_ok` is a single pulse in the cycle after `data_ok`.
- kuseg passthrough: `addr=32'h0040_0000` → `mreq.addr=32'h0040_0000`, `uncached=0`.
- Request change while busy: alter `creq.addr` during ADDR → `mreq.addr` is unchanged. The next transaction uses the `creq` value sampled in IDLE.
- Reset mid-transaction: assert `reset` in DATA → next cycle state is IDLE, `mreq.valid=0`, no `cresp.data_ok` pulse is produced.
